// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// signed/unsigned operands, divide-by-zero short path and annul while busy.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_END  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   rem_step, quot_step;
  logic [WIDTH-1:0]   rem_fix, quot_fix;

  // Magnitudes are plain WIDTH-bit unsigned, so the most-negative value maps to itself.
  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // dvd_q shifts out dividend bits from the top while quotient bits enter at the bottom.
  assign shifted   = {rem_q, dvd_q[WIDTH-1]};
  assign fits      = (shifted >= {1'b0, dvs_q});
  assign rem_step  = fits ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
  assign quot_step = {dvd_q[WIDTH-2:0], fits};
  assign quot_fix  = neg_quot_q ? -quot_step : quot_step;
  assign rem_fix   = neg_rem_q ? -rem_step : rem_step;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      ST_IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i != '0) begin
            dvd_d      = abs1;
            dvs_d      = abs2;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
            state_d    = ST_ON;
          end else begin
            ready_d = 1'b1;
            state_d = ST_END;
          end
        end
      end
      ST_ON: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          rem_d = rem_step;
          dvd_d = quot_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = {rem_fix, quot_fix};
            ready_d  = 1'b1;
            state_d  = ST_END;
          end
        end
      end
      ST_END: begin
        if (!start_i || annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: 32-bit and 8-bit instances, constant vector table,
// hand-written annul/reset sequences and a random sweep against an arithmetic model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;

  logic        sg32, st32, an32;
  logic [31:0] a32, b32;
  logic [63:0] r32;
  logic        rd32;

  logic        sg8, st8, an8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        rd8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32), .result_o(r32), .ready_o(rd32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sg8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8), .result_o(r8), .ready_o(rd8)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer division (truncating toward zero, remainder follows dividend).
  function automatic logic [63:0] ref_div(input int w, input bit sgn,
                                          input logic [31:0] a_in, input logic [31:0] b_in);
    longint mask, as, bs, q, r;
    logic [31:0] a, b;
    mask = (longint'(1) << w) - 1;
    a = a_in & 32'(mask);
    b = b_in & 32'(mask);
    as = longint'(a);
    bs = longint'(b);
    if (sgn && a[w-1]) as = as - (longint'(1) << w);
    if (sgn && b[w-1]) bs = bs - (longint'(1) << w);
    if (bs == 0) return 64'd0;
    q = as / bs;
    r = as % bs;
    return 64'(((r & mask) << w) | (q & mask));
  endfunction

  function automatic logic rdy(input int w);
    return (w == 32) ? rd32 : rd8;
  endfunction

  function automatic logic [63:0] res(input int w);
    return (w == 32) ? r32 : {48'd0, r8};
  endfunction

  task automatic raise(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      sg32 = sgn; a32 = a; b32 = b; st32 = 1'b1;
    end else begin
      sg8 = sgn; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1;
    end
  endtask

  task automatic wait_ready(input int w, output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (rdy(w)) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drop(input int w, input string name);
    if (w == 32) st32 = 1'b0; else st8 = 1'b0;
    @(posedge clk); #1;
    check({name, " ready_clr"}, 64'(rdy(w)), 64'd0);
    check({name, " result_clr"}, res(w), 64'd0);
  endtask

  task automatic run_ref(input int w, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input string name);
    int lat;
    logic [31:0] bm;
    bm = (w == 32) ? b : {24'd0, b[7:0]};
    raise(w, sgn, a, b);
    wait_ready(w, lat);
    check({name, " latency"}, 64'(lat), (bm == 0) ? 64'd1 : 64'(w + 1));
    check({name, " result"}, res(w), ref_div(w, sgn, a, b));
    drop(w, name);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [63:0] held;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          33};
    vecs[3] = '{1'b0, 32'd1234,       32'd0,          64'd0,                           1};
    vecs[4] = '{1'b1, 32'hFFFF_FF00,  32'd0,          64'd0,                           1};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          33};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},          33};

    rst = 1'b1;
    sg32 = 0; st32 = 0; an32 = 0; a32 = 0; b32 = 0;
    sg8 = 0; st8 = 0; an8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready32", 64'(rd32), 64'd0);
    check("reset result32", r32, 64'd0);
    check("reset ready8", 64'(rd8), 64'd0);
    rst = 1'b0;

    // 100/7 with start held past completion: END must hold outputs.
    raise(32, 1'b0, 32'd100, 32'd7);
    wait_ready(32, lat);
    check("t1 latency", 64'(lat), 64'd33);
    check("t1 result", r32, {32'd2, 32'd14});
    held = r32;
    repeat (2) @(posedge clk);
    #1;
    check("t1 hold ready", 64'(rd32), 64'd1);
    check("t1 hold result", r32, held);
    drop(32, "t1");

    for (int i = 0; i < 7; i++) begin
      raise(32, vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_ready(32, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d result", i), r32, vecs[i].exp);
      drop(32, $sformatf("vec%0d", i));
    end

    // annul while IDLE blocks acceptance; releasing it lets the held start in.
    an32 = 1'b1;
    raise(32, 1'b0, 32'd50, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    check("idle annul ready", 64'(rd32), 64'd0);
    an32 = 1'b0;
    wait_ready(32, lat);
    check("idle annul latency", 64'(lat), 64'd33);
    check("idle annul result", r32, {32'd0, 32'd10});
    drop(32, "idle annul");

    // annul on the 10th ON edge.
    raise(32, 1'b0, 32'd1000, 32'd10);
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    an32 = 1'b1;
    @(posedge clk); #1;
    check("annul ready", 64'(rd32), 64'd0);
    an32 = 1'b0;
    st32 = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rd32) seen = 1'b1;
    end
    check("annul never ready", 64'(seen), 64'd0);
    run_ref(32, 1'b0, 32'd12345, 32'd67, "after annul");

    // Reset on the 20th ON edge with start held throughout.
    raise(32, 1'b1, -32'sd1000, 32'd7);
    @(posedge clk); #1;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst ready", 64'(rd32), 64'd0);
    check("midrst result", r32, 64'd0);
    @(posedge clk); #1;
    sg32 = 1'b0; a32 = 32'd500; b32 = 32'd9;
    rst = 1'b0;
    wait_ready(32, lat);
    check("postrst latency", 64'(lat), 64'd33);
    check("postrst result", r32, {32'd5, 32'd55});
    drop(32, "postrst");

    raise(8, 1'b0, 32'd255, 32'd16);
    wait_ready(8, lat);
    check("w8 latency", 64'(lat), 64'd9);
    check("w8 result", res(8), {48'd0, 8'd15, 8'd15});
    drop(8, "w8");
    run_ref(8, 1'b1, 32'h80, 32'hFF, "w8 minneg");

    for (int w_sel = 0; w_sel < 2; w_sel++) begin
      for (int i = 0; i < 30; i++) begin
        ra = $urandom;
        case ($urandom_range(0, 3))
          0: rb = $urandom;
          1: rb = $urandom_range(0, 9);
          2: rb = -$urandom_range(1, 9);
          default: rb = $urandom >> $urandom_range(0, 31);
        endcase
        if ($urandom_range(0, 7) == 0) ra = (w_sel == 0) ? 32'h8000_0000 : 32'h80;
        run_ref((w_sel == 0) ? 32 : 8, 1'($urandom_range(0, 1)), ra, rb,
                $sformatf("rnd w%0d #%0d", (w_sel == 0) ? 32 : 8, i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
